// File: rtl/dlx_bus_master.sv
// dlx_bus_master: processor-side master for the DLX memory/IO bus.
// Turns a one-cycle CPU load/store request into the four-phase AS_N/ACK_N
// handshake, drives MAO/MDO/WR_N and captures read data from DI.
// Optional watchdog: define BUS_TIMEOUT_EN to abort a transaction when the
// slave does not produce the awaited ACK_N level within TIMEOUT_CYC cycles.
module dlx_bus_master #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        AS_N,
    output logic        WR_N,
    output logic [31:0] MAO,
    output logic [31:0] MDO,
    input  logic        ACK_N,
    input  logic [31:0] DI
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RELEASE
    } state_t;

    state_t state;

    // The watchdog needs at least one waiting cycle before it may fire.
    if (TIMEOUT_CYC < 2) begin : g_timeout_range
        $error("TIMEOUT_CYC must be at least 2");
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    // The abort fires on the edge where this many waits have already elapsed,
    // so the counter stops at LIMIT and can never wrap.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt;
`endif

    // Handshake sequencer: every output is a flop updated here.
    // NOTE: all state and outputs use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            AS_N  <= 1'b1;
            WR_N  <= 1'b1;
            MAO   <= '0;
            MDO   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            RDATA <= '0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            // DONE/ERR are single-cycle pulses unless re-asserted below.
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ) begin
                        MAO   <= ADDR;
                        MDO   <= WDATA;
                        WR_N  <= ~WE;
                        AS_N  <= 1'b0;
                        BUSY  <= 1'b1;
                        state <= WAIT_ACK;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                WAIT_ACK: begin
                    if (!ACK_N) begin
                        // WR_N still holds the direction of this transfer.
                        if (WR_N) begin
                            RDATA <= DI;
                        end
                        AS_N  <= 1'b1;
                        WR_N  <= 1'b1;
                        state <= RELEASE;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == LIMIT) begin
                        AS_N  <= 1'b1;
                        WR_N  <= 1'b1;
                        DONE  <= 1'b1;
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end

                RELEASE: begin
                    if (ACK_N) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
`ifdef BUS_TIMEOUT_EN
                    end else if (wait_cnt == LIMIT) begin
                        DONE  <= 1'b1;
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dlx_bus_master.sv
// Testbench for dlx_bus_master: a behavioural bus slave, a transaction-level
// reference model checked against the DUT every cycle, and directed
// scenarios with hand-computed expectations.
module tb_dlx_bus_master;

    localparam int TIMEOUT_CYC = 16;
    localparam logic [31:0] IDLE_DI = 32'hBAD0_BAD0;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] WDATA = '0;
    logic        ACK_N = 1'b1;
    logic [31:0] DI = IDLE_DI;
    logic        BUSY, DONE, ERR, AS_N, WR_N;
    logic [31:0] RDATA, MAO, MDO;

    dlx_bus_master #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .AS_N(AS_N), .WR_N(WR_N), .MAO(MAO), .MDO(MDO),
        .ACK_N(ACK_N), .DI(DI)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural slave: acks s_delay cycles after seeing AS_N low, releases
    // ACK_N once AS_N returns high. Unwritten words read as 0x12345678.
    logic [31:0] mem [16];
    logic [15:0] written = '0;
    int          s_delay = 0;
    int          s_cnt = 0;
    bit          s_dead = 1'b0;

    always @(negedge CLK) begin
        if (AS_N === 1'b0 && !s_dead) begin
            if (ACK_N) begin
                if (s_cnt >= s_delay) begin
                    ACK_N <= 1'b0;
                    if (!WR_N) begin
                        mem[MAO[5:2]]     <= MDO;
                        written[MAO[5:2]] <= 1'b1;
                    end
                    DI <= written[MAO[5:2]] ? mem[MAO[5:2]] : 32'h1234_5678;
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end
        end else begin
            ACK_N <= 1'b1;
            DI    <= IDLE_DI;
            s_cnt <= 0;
        end
    end

    // Reference model: tracks the outstanding transaction as "issued" and
    // "acknowledged" facts; outputs follow from those.
    bit          m_active = 1'b0;
    bit          m_acked = 1'b0;
    bit          m_we = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    int          m_wait = 0;
    int          n_issued = 0;
    logic [31:0] m_mao = '0;
    logic [31:0] m_mdo = '0;
    logic [31:0] m_rdata = '0;

    always @(posedge CLK) begin
        m_done <= 1'b0;
        m_err  <= 1'b0;
        if (RST) begin
            m_active <= 1'b0;
            m_acked  <= 1'b0;
            m_mao    <= '0;
            m_mdo    <= '0;
            m_rdata  <= '0;
        end else if (!m_active) begin
            if (REQ) begin
                m_active <= 1'b1;
                m_acked  <= 1'b0;
                m_we     <= WE;
                m_mao    <= ADDR;
                m_mdo    <= WDATA;
                m_wait   <= 0;
                n_issued <= n_issued + 1;
            end
        end else if (ACK_N == m_acked) begin
            // awaited level seen: low before the ack, high after it
            if (!m_acked) begin
                m_acked <= 1'b1;
                m_wait  <= 0;
                if (!m_we) m_rdata <= DI;
            end else begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end else begin
`ifdef BUS_TIMEOUT_EN
            if (m_wait + 1 >= TIMEOUT_CYC) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_err    <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
`else
            m_wait <= m_wait + 1;
`endif
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    bit chk_en = 1'b0;
    always @(negedge CLK) begin
        if (chk_en) begin
            check("as_n",  32'(AS_N),  32'(!(m_active && !m_acked)));
            check("wr_n",  32'(WR_N),  32'(!(m_active && !m_acked && m_we)));
            check("busy",  32'(BUSY),  32'(m_active));
            check("done",  32'(DONE),  32'(m_done));
            check("err",   32'(ERR),   32'(m_err));
            check("mao",   MAO,   m_mao);
            check("mdo",   MDO,   m_mdo);
            check("rdata", RDATA, m_rdata);
        end
    end

    // Called at a negedge; returns at the negedge right after REQ was sampled.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        REQ   = 1'b1;
        WE    = we;
        ADDR  = addr;
        WDATA = wdata;
        @(negedge CLK);
        REQ = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        while (DONE !== 1'b1 && cycles < max) begin
            @(negedge CLK);
            cycles++;
        end
        if (DONE !== 1'b1) check("done_wait_expired", 32'(DONE), 32'd1);
    endtask

    int cyc, done_cnt, low_cnt, busy_cnt, issued0;

    initial begin
        // Reset with REQ high: reset must win.
        RST = 1'b1; REQ = 1'b1; WE = 1'b1; ADDR = 32'hFFFF_FFFC; WDATA = 32'hFFFF_0000;
        @(posedge CLK);
        chk_en = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            check("rst_as_n", 32'(AS_N), 32'd1);
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_mao",  MAO, 32'd0);
        end
        RST = 1'b0; REQ = 1'b0;
        @(negedge CLK);

        // Read of 0x4, slave acks 3 cycles after strobe.
        s_delay = 3;
        issue(1'b0, 32'h4, 32'h0);
        check("rd_strobe_as_n", 32'(AS_N), 32'd0);
        check("rd_strobe_wr_n", 32'(WR_N), 32'd1);
        check("rd_strobe_mao",  MAO, 32'h4);
        wait_done(50, cyc);
        check("rd_latency", cyc, 32'd5);
        check("rd_rdata", RDATA, 32'h1234_5678);
        check("rd_err", 32'(ERR), 32'd0);
        @(negedge CLK);
        check("rd_done_one_cycle", 32'(DONE), 32'd0);

        // Writes with an immediate slave, then read-after-write.
        s_delay = 0;
        issue(1'b1, 32'h4, 32'h1234_5678);
        check("wr_strobe_wr_n", 32'(WR_N), 32'd0);
        check("wr_strobe_mdo",  MDO, 32'h1234_5678);
        wait_done(50, cyc);
        check("wr_min_latency", cyc, 32'd2);
        check("wr_after_wr_n", 32'(WR_N), 32'd1);
        @(negedge CLK);
        issue(1'b0, 32'h4, 32'h0);
        wait_done(50, cyc);
        check("raw4_rdata", RDATA, 32'h1234_5678);
        @(negedge CLK);
        issue(1'b1, 32'h8, 32'hA5A5_5A5A);
        wait_done(50, cyc);
        @(negedge CLK);
        issue(1'b0, 32'h8, 32'h0);
        wait_done(50, cyc);
        check("raw8_rdata", RDATA, 32'hA5A5_5A5A);
        @(negedge CLK);
        issue(1'b1, 32'hC, 32'h0BAD_F00D);
        wait_done(50, cyc);
        check("wr_keeps_rdata", RDATA, 32'hA5A5_5A5A);
        @(negedge CLK);
        check("mao_retained", MAO, 32'hC);
        check("mdo_retained", MDO, 32'h0BAD_F00D);

        // Back-to-back: REQ held high for 12 edges, 3 cycles per transfer.
        done_cnt = 0; low_cnt = 0; issued0 = n_issued;
        REQ = 1'b1; WE = 1'b0; ADDR = 32'h8;
        repeat (12) begin
            @(negedge CLK);
            if (DONE === 1'b1) done_cnt++;
            if (AS_N === 1'b0) low_cnt++;
        end
        REQ = 1'b0;
        check("b2b_done_count", done_cnt, 32'd4);
        check("b2b_strobe_count", low_cnt, 32'd4);
        check("b2b_model_issued", n_issued - issued0, 32'd4);
        check("b2b_rdata", RDATA, 32'hA5A5_5A5A);
        @(negedge CLK);

        // Unresponsive slave.
        s_dead = 1'b1;
        issue(1'b0, 32'h10, 32'h0);
`ifdef BUS_TIMEOUT_EN
        wait_done(40, cyc);
        check("to_wait_cycles", cyc, 32'd16);
        check("to_err", 32'(ERR), 32'd1);
        check("to_as_n", 32'(AS_N), 32'd1);
        check("to_rdata_kept", RDATA, 32'hA5A5_5A5A);
`else
        busy_cnt = 0; done_cnt = 0;
        repeat (100) begin
            @(negedge CLK);
            if (BUSY === 1'b1) busy_cnt++;
            if (DONE === 1'b1) done_cnt++;
        end
        check("hang_busy_cycles", busy_cnt, 32'd100);
        check("hang_no_done", done_cnt, 32'd0);
        check("hang_as_n", 32'(AS_N), 32'd0);
`endif
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; s_dead = 1'b0;
        check("rst_clears_rdata", RDATA, 32'd0);
        check("rst_clears_busy", 32'(BUSY), 32'd0);

        // Reset while waiting for ACK_N.
        s_delay = 5;
        issue(1'b0, 32'h4, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_as_n", 32'(AS_N), 32'd1);
        check("midrst_busy", 32'(BUSY), 32'd0);
        done_cnt = 0;
        repeat (5) begin
            @(negedge CLK);
            if (DONE === 1'b1) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 32'd0);
        s_delay = 0;
        issue(1'b0, 32'h8, 32'h0);
        wait_done(50, cyc);
        check("post_rst_latency", cyc, 32'd2);
        check("post_rst_rdata", RDATA, 32'hA5A5_5A5A);
        check("post_rst_err", 32'(ERR), 32'd0);
        @(negedge CLK);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
